// File: rtl/argument_arbiter_pkg.sv
// argument_arbiter_pkg
//   Shared types and helpers for the argument arbiter and its decoder.
//   - arb_state_t : arbiter FSM states (IDLE, POP, SETTLE)
//   - len_mask    : low-bit mask of a given length, (1<<len)-1
//   - log2_ceil   : ceiling log2 used to size pop/length/grant fields
package argument_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    POP    = 2'd1,
    SETTLE = 2'd2
  } arb_state_t;

  // Widest mask the helper can produce; callers truncate to their width.
  localparam int MASK_MAX = 256;

  function automatic logic [MASK_MAX-1:0] len_mask(input logic [7:0] len);
    len_mask = ~({MASK_MAX{1'b1}} << len);
  endfunction

  function automatic int log2_ceil(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/argument_arbiter_rr_picker.sv
// rr_priority_picker
//   Purely combinational round-robin search. Candidates are visited in
//   order last_gnt+1, last_gnt+2, ... with wrap at NUM_REQ; the first
//   requesting candidate wins.
//   Ports:
//     req      in  NUM_REQ       request vector
//     last_gnt in  LOG2_NUM_REQ  most recently granted index
//     winner   out LOG2_NUM_REQ  chosen index (0 when nothing requests)
//     any_req  out 1             at least one request is present
module rr_priority_picker #(
  parameter int NUM_REQ      = 4,
  parameter int LOG2_NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]      req,
  input  logic [LOG2_NUM_REQ-1:0] last_gnt,
  output logic [LOG2_NUM_REQ-1:0] winner,
  output logic                    any_req
);

  localparam int SW = LOG2_NUM_REQ + 1;

  logic [LOG2_NUM_REQ-1:0] cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0]      rot_req;

  // rot_req[k] is the request of the k-th candidate after last_gnt, so the
  // lowest set bit of rot_req is the round-robin winner. last_gnt is always
  // below NUM_REQ, so a single conditional subtract performs the wrap.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      logic [SW-1:0] raw_sum;
      assign raw_sum      = {1'b0, last_gnt} + SW'(gi + 1);
      assign cand_idx[gi] = (raw_sum >= SW'(NUM_REQ)) ?
                            LOG2_NUM_REQ'(raw_sum - SW'(NUM_REQ)) :
                            LOG2_NUM_REQ'(raw_sum);
      assign rot_req[gi]  = req[cand_idx[gi]];
    end
  endgenerate

  always_comb begin
    winner = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot_req[i]) winner = cand_idx[i];
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/argument_arbiter.sv
// argument_arbiter
//   Shares one variable-length bit decoder between NUM_REQ requesters.
//   In IDLE with dec_ready high, a round-robin winner is chosen and its
//   LSB-aligned field is captured from dec_q. The following cycle (POP)
//   presents dec_pop and a one-hot rsp_valid strobe; SETTLE then gives the
//   decoder a cycle to update ready before the next arbitration.
//   Optional build macro ARGUMENT_ARBITER_STATS_EN adds a running count of
//   consumed bits on bits_consumed.
//   Ports:
//     clk           in  1                       rising-edge clock
//     rst           in  1                       synchronous, active-low reset
//     req           in  NUM_REQ                 request levels
//     req_len       in  NUM_REQ*LOG2_WIDTH_OUT  packed field lengths
//     dec_ready     in  1                       decoder has WIDTH_OUT valid bits
//     dec_q         in  WIDTH_OUT               decoder head, bit 0 oldest
//     dec_pop       out LOG2_WIDTH_OUT          bits to consume (0 = none)
//     rsp_valid     out NUM_REQ                 one-hot response strobe
//     rsp_data      out WIDTH_OUT               returned field, zero above length
//     bits_consumed out 32                      (stats build only) total popped
//     busy          out 1                       FSM not in IDLE
module argument_arbiter
  import argument_arbiter_pkg::*;
#(
  parameter int WIDTH_OUT      = 64,
  parameter int LOG2_WIDTH_OUT = log2_ceil(WIDTH_OUT),
  parameter int NUM_REQ        = 4,
  parameter int LOG2_NUM_REQ   = log2_ceil(NUM_REQ)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req,
  input  logic [NUM_REQ*LOG2_WIDTH_OUT-1:0]   req_len,
  input  logic                                dec_ready,
  input  logic [WIDTH_OUT-1:0]                dec_q,
  output logic [LOG2_WIDTH_OUT-1:0]           dec_pop,
  output logic [NUM_REQ-1:0]                  rsp_valid,
  output logic [WIDTH_OUT-1:0]                rsp_data,
`ifdef ARGUMENT_ARBITER_STATS_EN
  output logic [31:0]                         bits_consumed,
`endif
  output logic                                busy
);

  arb_state_t                state_reg;
  logic [LOG2_NUM_REQ-1:0]   last_gnt_reg;
  logic [LOG2_NUM_REQ-1:0]   win_reg;
  logic [LOG2_NUM_REQ-1:0]   pick_idx;
  logic                      pick_any;
  logic [LOG2_WIDTH_OUT-1:0] pick_len;

  rr_priority_picker #(
    .NUM_REQ      (NUM_REQ),
    .LOG2_NUM_REQ (LOG2_NUM_REQ)
  ) u_picker (
    .req      (req),
    .last_gnt (last_gnt_reg),
    .winner   (pick_idx),
    .any_req  (pick_any)
  );

  assign pick_len = req_len[pick_idx*LOG2_WIDTH_OUT +: LOG2_WIDTH_OUT];
  assign busy     = (state_reg != IDLE);

  // Outputs are loaded on the IDLE->POP edge so they are visible during
  // POP, and cleared on the POP->SETTLE edge. rsp_data holds its last value
  // until the next capture. During POP dec_pop equals the latched length,
  // so it doubles as the stats increment.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      last_gnt_reg  <= LOG2_NUM_REQ'(NUM_REQ - 1);
      win_reg       <= '0;
      dec_pop       <= '0;
      rsp_valid     <= '0;
      rsp_data      <= '0;
`ifdef ARGUMENT_ARBITER_STATS_EN
      bits_consumed <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (dec_ready && pick_any) begin
            win_reg   <= pick_idx;
            dec_pop   <= pick_len;
            rsp_valid <= NUM_REQ'(1) << pick_idx;
            rsp_data  <= dec_q & WIDTH_OUT'(len_mask(8'(pick_len)));
            state_reg <= POP;
          end
        end
        POP: begin
          dec_pop       <= '0;
          rsp_valid     <= '0;
          last_gnt_reg  <= win_reg;
`ifdef ARGUMENT_ARBITER_STATS_EN
          bits_consumed <= bits_consumed + 32'(dec_pop);
`endif
          state_reg     <= SETTLE;
        end
        SETTLE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_argument_arbiter.sv
// tb_argument_arbiter
//   Randomized and directed stimulus against a transaction-level reference
//   model (round-robin search over an integer last-grant and a cycle
//   cooldown counter). One line is printed per grant.
module tb_argument_arbiter;

  localparam int W  = 64;
  localparam int LW = 6;
  localparam int N  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N*LW-1:0] req_len;
  logic          dec_ready;
  logic [W-1:0]  dec_q;
  logic [LW-1:0] dec_pop;
  logic [N-1:0]  rsp_valid;
  logic [W-1:0]  rsp_data;
  logic          busy;
`ifdef ARGUMENT_ARBITER_STATS_EN
  logic [31:0]   bits_consumed;
`endif

  argument_arbiter #(
    .WIDTH_OUT (W),
    .NUM_REQ   (N)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .req_len       (req_len),
    .dec_ready     (dec_ready),
    .dec_q         (dec_q),
    .dec_pop       (dec_pop),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
`ifdef ARGUMENT_ARBITER_STATS_EN
    .bits_consumed (bits_consumed),
`endif
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  int            m_last;
  int            m_cool;
  int            m_len;
  logic [N-1:0]  e_valid;
  logic [LW-1:0] e_pop;
  logic [W-1:0]  e_data;
  logic [31:0]   e_bits;
  bit            granted [N];

  function automatic int get_len(input int i);
    logic [N*LW-1:0] v;
    v = req_len;
    return int'(v[i*LW +: LW]);
  endfunction

  task automatic set_len(input int i, input int v);
    req_len[i*LW +: LW] = LW'(v);
  endtask

  // One clock: model consumes the inputs sampled at this edge, then the
  // DUT outputs are compared 1 time unit later.
  task automatic step();
    int w;
    @(posedge clk);
    if (!rst) begin
      m_last = N - 1; m_cool = 0; e_valid = '0; e_pop = '0; e_data = '0; e_bits = '0;
    end else if (m_cool > 0) begin
      if (m_cool == 2) e_bits = e_bits + 32'(m_len);
      m_cool--;
      e_valid = '0; e_pop = '0;
    end else if (dec_ready && req != '0) begin
      w = -1;
      for (int k = 1; k <= N && w < 0; k++) begin
        if (req[(m_last + k) % N]) w = (m_last + k) % N;
      end
      m_len   = get_len(w);
      e_valid = N'(1) << w;
      e_pop   = LW'(m_len);
      e_data  = dec_q & ((64'd1 << m_len) - 64'd1);
      m_cool  = 2;
      m_last  = w;
      granted[w] = 1'b1;
      $display("grant requester=%0d len=%0d data=%h", w, m_len, e_data);
    end else begin
      e_valid = '0; e_pop = '0;
    end
    #1;
    check_val("rsp_valid", rsp_valid, e_valid);
    check_val("dec_pop", dec_pop, e_pop);
    check_val("rsp_data", rsp_data, e_data);
    check_val("busy", busy, m_cool > 0);
`ifdef ARGUMENT_ARBITER_STATS_EN
    check_val("bits_consumed", bits_consumed, e_bits);
`endif
  endtask

  logic [N-1:0] order_q [$];
  int           cyc_q   [$];

  initial begin
    m_last = N - 1; m_cool = 0; m_len = 0;
    e_valid = '0; e_pop = '0; e_data = '0; e_bits = '0;
    for (int i = 0; i < N; i++) granted[i] = 1'b0;

    // Reset values
    rst = 1'b0; req = '0; req_len = '0; dec_ready = 1'b0; dec_q = '0;
    step(); step();
    check_val("reset_busy", busy, 1'b0);
    check_val("reset_valid", rsp_valid, '0);

    // Single requester, length 5
    rst = 1'b1; req = 4'b0001; set_len(0, 5); dec_q = 64'hFF; dec_ready = 1'b1;
    step();
    check_val("single_valid", rsp_valid, 4'b0001);
    check_val("single_data", rsp_data, 64'h1F);
    check_val("single_pop", dec_pop, 6'd5);
    req = '0;
    step();
    check_val("single_busy_settle", busy, 1'b1);
    check_val("single_pop_cleared", dec_pop, 6'd0);
    step();
    check_val("single_idle", busy, 1'b0);

    // All four requesting with length 8, fresh from reset
    rst = 1'b0; step();
    rst = 1'b1; req = 4'b1111;
    for (int i = 0; i < N; i++) set_len(i, 8);
    for (int c = 0; c < 15; c++) begin
      dec_q = {$urandom, $urandom};
      step();
      if (rsp_valid != '0) begin
        order_q.push_back(rsp_valid);
        cyc_q.push_back(c);
      end
    end
    check_val("rr_count", order_q.size(), 5);
    for (int k = 0; k < order_q.size() && k < 5; k++) begin
      check_val("rr_order", order_q[k], N'(1) << (k % N));
      if (k > 0) check_val("rr_spacing", cyc_q[k] - cyc_q[k-1], 3);
    end

    // dec_ready low holds everything off; raising it grants requester 0
    rst = 1'b0; step();
    rst = 1'b1; dec_ready = 1'b0; req = 4'b1111;
    set_len(0, 7); set_len(1, 0); set_len(2, 3); set_len(3, 9);
    for (int c = 0; c < 5; c++) begin
      dec_q = {$urandom, $urandom};
      step();
      check_val("held_valid", rsp_valid, '0);
      check_val("held_pop", dec_pop, '0);
    end
    dec_ready = 1'b1;
    step();
    check_val("ready_rise_grant", rsp_valid, 4'b0001);

    // Zero-length field for requester 1
    req = 4'b0010;
    step(); step();
    dec_q = 64'hDEAD_BEEF_CAFE_F00D;
    step();
    check_val("len0_valid", rsp_valid, 4'b0010);
    check_val("len0_data", rsp_data, 64'd0);
    check_val("len0_pop", dec_pop, 6'd0);
    req = '0;
    step(); step();

    // Reset during POP returns to IDLE and restarts search at requester 0
    req = 4'b1111;
    for (int i = 0; i < N; i++) set_len(i, int'($urandom_range(1, 63)));
    step();
    check_val("pre_reset_busy", busy, 1'b1);
    rst = 1'b0;
    step();
    check_val("rst_pop_valid", rsp_valid, '0);
    check_val("rst_pop_pop", dec_pop, '0);
    check_val("rst_pop_data", rsp_data, '0);
    check_val("rst_pop_busy", busy, 1'b0);
    rst = 1'b1;
    step();
    check_val("rst_pop_regrant", rsp_valid, 4'b0001);
    req = '0;
    step(); step();
    for (int i = 0; i < N; i++) granted[i] = 1'b0;

    // Randomized traffic under the requester contract
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++) begin
        if (granted[i]) begin
          granted[i] = 1'b0;
          if ($urandom_range(0, 2) == 0) set_len(i, int'($urandom_range(0, 63)));
          else req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
          set_len(i, int'($urandom_range(0, 63)));
        end
      end
      dec_ready = ($urandom_range(0, 4) != 0);
      dec_q     = {$urandom, $urandom};
      rst       = ($urandom_range(0, 99) != 0);
      step();
    end

`ifdef ARGUMENT_ARBITER_STATS_EN
    // Pops of 63, 63 and 10 accumulate to 136
    rst = 1'b0; req = '0; step();
    rst = 1'b1; dec_ready = 1'b1; req = 4'b0001;
    set_len(0, 63); step(); step(); step();
    set_len(0, 63); step(); step(); step();
    set_len(0, 10); step();
    req = '0; step(); step();
    check_val("stats_total", bits_consumed, 32'd136);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
